// File: rtl/pc_npc_unit.sv
// pc_npc_unit: PC/nPC fetch-address pair with delay-slot/annul FSM.
// Optional PC_ALIGN_CHECK_EN: word-aligns redirect targets and flags misaligned ones.
module pc_npc_unit (
  input  logic        clk,
  input  logic        R,
  input  logic        LE,
  input  logic [1:0]  nPC_sel,
  input  logic        IF_ID_R,
  input  logic [31:0] TAG,
  input  logic [31:0] ALU_OUT,
  output logic [31:0] PC,
  output logic [31:0] nPC,
  output logic        delay_slot,
  output logic        annul,
  output logic [1:0]  state,
  output logic        misalign
);
  typedef enum logic [1:0] {RST, RUN, DSLOT, ANNUL} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, npc_q, npc_d, tgt, tgt_ld;
  logic redir, adv;
  always_comb begin
    redir = nPC_sel == 2'b01 || nPC_sel == 2'b10;
    tgt = nPC_sel == 2'b01 ? TAG : ALU_OUT;
    adv = LE && state_q != RST;
    pc_d = adv ? npc_q : pc_q;
    npc_d = !adv ? npc_q : redir ? tgt_ld : npc_q + 32'd4;
    // a redirect outranks a flush; a flush during ANNUL is ignored
    state_d = state_q == RST ? RUN :
              !LE ? state_q :
              redir ? DSLOT :
              (IF_ID_R && state_q != ANNUL) ? ANNUL : RUN;
  end
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_q <= RST;
      pc_q <= 32'h0;
      npc_q <= 32'h4;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      npc_q <= npc_d;
    end
  end
`ifdef PC_ALIGN_CHECK_EN
  logic mis_q, mis_d;
  assign tgt_ld = {tgt[31:2], 2'b00};
  assign mis_d = mis_q || (adv && redir && tgt[1:0] != 2'b00);
  always_ff @(posedge clk or posedge R) begin
    if (R) mis_q <= 1'b0;
    else mis_q <= mis_d;
  end
  assign misalign = mis_q;
`else
  assign tgt_ld = tgt;
  assign misalign = 1'b0;
`endif
  assign PC = pc_q;
  assign nPC = npc_q;
  assign state = state_q;
  assign delay_slot = state_q == DSLOT;
  assign annul = state_q == ANNUL;
endmodule

// File: tb/tb_pc_npc_unit.sv
// tb_pc_npc_unit: scoreboard bench for pc_npc_unit; expectations follow PC_ALIGN_CHECK_EN.
module tb_pc_npc_unit;
  logic clk = 1'b0, R = 1'b1, LE = 1'b0, IF_ID_R = 1'b0;
  logic [1:0] nPC_sel = 2'b00;
  logic [31:0] TAG = 32'h0, ALU_OUT = 32'h0;
  logic [31:0] PC, nPC;
  logic delay_slot, annul, misalign;
  logic [1:0] state;
  logic [68:0] obs, e;
  logic [68:0] sb[$];
  logic em = 1'b0;
  int checks = 0, errs = 0;

  typedef struct packed {
    logic le; logic [1:0] sel; logic iir; logic [31:0] tgt;
    logic [31:0] p; logic [31:0] n; logic [1:0] s;
  } vec_t;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic MACRO = 1'b1;
  localparam logic [31:0] AL_N = 32'h200, AL_N2 = 32'h204;
`else
  localparam logic MACRO = 1'b0;
  localparam logic [31:0] AL_N = 32'h203, AL_N2 = 32'h207;
`endif

  pc_npc_unit dut (
    .clk(clk), .R(R), .LE(LE), .nPC_sel(nPC_sel), .IF_ID_R(IF_ID_R),
    .TAG(TAG), .ALU_OUT(ALU_OUT), .PC(PC), .nPC(nPC),
    .delay_slot(delay_slot), .annul(annul), .state(state), .misalign(misalign)
  );

  always #5 clk = ~clk;
  assign obs = {PC, nPC, state, delay_slot, annul, misalign};

  function automatic logic [68:0] pk(input logic [31:0] p, input logic [31:0] n,
                                     input logic [1:0] s, input logic m);
    return {p, n, s, s == 2'd2, s == 2'd3, m};
  endfunction

  task automatic step(input logic le, input logic [1:0] sel, input logic iir,
                      input logic [31:0] tag, input logic [31:0] alu);
    LE = le; nPC_sel = sel; IF_ID_R = iir; TAG = tag; ALU_OUT = alu;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    vec_t v[3];
    v = '{'{1'b1, 2'd0, 1'b0, 32'h0, 32'h0, 32'h4, 2'd1},
          '{1'b1, 2'd0, 1'b0, 32'h0, 32'h4, 32'h8, 2'd1},
          '{1'b1, 2'd0, 1'b0, 32'h0, 32'h8, 32'hC, 2'd1}};
    R = 1'b1; LE = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(pk(32'h0, 32'h4, 2'd0, 1'b0));
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errs++; $display("FAIL reset_hold: got %h want %h", obs, e); end
    R = 1'b0;
    foreach (v[i]) begin
      sb.push_back(pk(v[i].p, v[i].n, v[i].s, em));
      step(v[i].le, v[i].sel, v[i].iir, v[i].tgt, v[i].tgt);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errs++; $display("FAIL reset_seq[%0d]: got %h want %h", i, obs, e); end
    end
  endtask

  task automatic test_branch;
    vec_t v[8];
    v = '{'{1'b1, 2'd1, 1'b0, 32'h100, 32'hC,   32'h100, 2'd2},
          '{1'b1, 2'd0, 1'b0, 32'h0,   32'h100, 32'h104, 2'd1},
          '{1'b1, 2'd1, 1'b0, 32'h200, 32'h104, 32'h200, 2'd2},
          '{1'b1, 2'd2, 1'b0, 32'h300, 32'h200, 32'h300, 2'd2},
          '{1'b1, 2'd0, 1'b0, 32'h0,   32'h300, 32'h304, 2'd1},
          '{1'b1, 2'd1, 1'b1, 32'h500, 32'h304, 32'h500, 2'd2},
          '{1'b1, 2'd0, 1'b0, 32'h0,   32'h500, 32'h504, 2'd1},
          '{1'b1, 2'd1, 1'b0, 32'h1C,  32'h504, 32'h1C,  2'd2}};
    foreach (v[i]) begin
      sb.push_back(pk(v[i].p, v[i].n, v[i].s, em));
      step(v[i].le, v[i].sel, v[i].iir, v[i].tgt, v[i].tgt);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errs++; $display("FAIL branch[%0d]: got %h want %h", i, obs, e); end
    end
  endtask

  task automatic test_annul;
    vec_t v[7];
    v = '{'{1'b1, 2'd0, 1'b0, 32'h0,   32'h1C, 32'h20,  2'd1},
          '{1'b1, 2'd0, 1'b0, 32'h0,   32'h20, 32'h24,  2'd1},
          '{1'b1, 2'd0, 1'b1, 32'h0,   32'h24, 32'h28,  2'd3},
          '{1'b1, 2'd0, 1'b1, 32'h0,   32'h28, 32'h2C,  2'd1},
          '{1'b1, 2'd3, 1'b0, 32'h900, 32'h2C, 32'h30,  2'd1},
          '{1'b1, 2'd0, 1'b1, 32'h0,   32'h30, 32'h34,  2'd3},
          '{1'b1, 2'd2, 1'b1, 32'h600, 32'h34, 32'h600, 2'd2}};
    foreach (v[i]) begin
      sb.push_back(pk(v[i].p, v[i].n, v[i].s, em));
      step(v[i].le, v[i].sel, v[i].iir, v[i].tgt, v[i].tgt);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errs++; $display("FAIL annul[%0d]: got %h want %h", i, obs, e); end
    end
  endtask

  task automatic test_stall;
    vec_t v[6];
    v = '{'{1'b1, 2'd0, 1'b0, 32'h0,   32'h600, 32'h604, 2'd1},
          '{1'b0, 2'd2, 1'b0, 32'h400, 32'h600, 32'h604, 2'd1},
          '{1'b0, 2'd2, 1'b1, 32'h400, 32'h600, 32'h604, 2'd1},
          '{1'b0, 2'd2, 1'b0, 32'h400, 32'h600, 32'h604, 2'd1},
          '{1'b1, 2'd2, 1'b0, 32'h400, 32'h604, 32'h400, 2'd2},
          '{1'b0, 2'd1, 1'b1, 32'h800, 32'h604, 32'h400, 2'd2}};
    foreach (v[i]) begin
      sb.push_back(pk(v[i].p, v[i].n, v[i].s, em));
      step(v[i].le, v[i].sel, v[i].iir, v[i].tgt, v[i].tgt);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errs++; $display("FAIL stall[%0d]: got %h want %h", i, obs, e); end
    end
  endtask

  task automatic test_align_wrap;
    vec_t v[6];
    v = '{'{1'b1, 2'd2, 1'b0, 32'h203,      32'h400,      AL_N,         2'd2},
          '{1'b1, 2'd0, 1'b0, 32'h0,        AL_N,         AL_N2,        2'd1},
          '{1'b1, 2'd1, 1'b0, 32'hFFFFFFF8, AL_N2,        32'hFFFFFFF8, 2'd2},
          '{1'b1, 2'd0, 1'b0, 32'h0,        32'hFFFFFFF8, 32'hFFFFFFFC, 2'd1},
          '{1'b1, 2'd0, 1'b0, 32'h0,        32'hFFFFFFFC, 32'h0,        2'd1},
          '{1'b1, 2'd0, 1'b0, 32'h0,        32'h0,        32'h4,        2'd1}};
    em = MACRO;
    foreach (v[i]) begin
      sb.push_back(pk(v[i].p, v[i].n, v[i].s, em));
      step(v[i].le, v[i].sel, v[i].iir, v[i].tgt, v[i].tgt);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errs++; $display("FAIL align_wrap[%0d]: got %h want %h", i, obs, e); end
    end
  endtask

  task automatic test_async_reset;
    sb.push_back(pk(32'h4, 32'h40, 2'd2, em));
    step(1'b1, 2'd1, 1'b0, 32'h40, 32'h0);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errs++; $display("FAIL arst_pre: got %h want %h", obs, e); end
    em = 1'b0;
    #3 R = 1'b1;
    #1;
    sb.push_back(pk(32'h0, 32'h4, 2'd0, 1'b0));
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errs++; $display("FAIL arst_now: got %h want %h", obs, e); end
    sb.push_back(pk(32'h0, 32'h4, 2'd0, 1'b0));
    step(1'b1, 2'd2, 1'b1, 32'h0, 32'h77C);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errs++; $display("FAIL arst_hold: got %h want %h", obs, e); end
    #3 R = 1'b0;
    sb.push_back(pk(32'h0, 32'h4, 2'd1, 1'b0));
    step(1'b0, 2'd1, 1'b1, 32'h88, 32'h0);
    e = sb.pop_front(); checks++;
    if (obs !== e) begin errs++; $display("FAIL arst_le0: got %h want %h", obs, e); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] mp, mn, t, tg, al;
    logic [1:0] ms, sel;
    logic mm, le, iir;
    mp = 32'h0; mn = 32'h4; ms = 2'd1; mm = 1'b0;
    for (int i = 0; i < 300; i++) begin
      le = $urandom_range(0, 3) != 0;
      sel = 2'($urandom_range(0, 3));
      iir = $urandom_range(0, 2) == 0;
      tg = $urandom & ($urandom_range(0, 7) == 0 ? 32'hFFFFFFFF : 32'hFFFFFFFC);
      al = $urandom & ($urandom_range(0, 7) == 0 ? 32'hFFFFFFFF : 32'hFFFFFFFC);
      if (le) begin
        mp = mn;
        if (sel == 2'd1 || sel == 2'd2) begin
          t = sel == 2'd1 ? tg : al;
          if (MACRO) begin
            mm = mm | (t[1:0] != 2'b00);
            t[1:0] = 2'b00;
          end
          mn = t;
          ms = 2'd2;
        end else begin
          mn = mn + 32'd4;
          ms = (iir && ms != 2'd3) ? 2'd3 : 2'd1;
        end
      end
      sb.push_back(pk(mp, mn, ms, mm));
      step(le, sel, iir, tg, al);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errs++; $display("FAIL b2b[%0d]: got %h want %h", i, obs, e); end
    end
  endtask

  initial begin
    test_reset;
    test_branch;
    test_annul;
    test_stall;
    test_align_wrap;
    test_async_reset;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
